// File: rtl/crc_pkg.sv
// Shared definitions for the serial CRC front end, the CRC engine and their benches.
package crc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    SHIFT,
    COLLECT,
    HOLD
  } state_t;

  localparam int unsigned CRC_DATA_WIDTH = 8;
  localparam int unsigned CRC_CRC_WIDTH  = 8;
  localparam int unsigned CRC_TIMEOUT    = 32;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/crc_serial_frontend.sv
// Parallel-to-serial front end for the serial CRC engine: serialises a word LSB-first,
// collects the returned serial CRC bits and presents them as a parallel word.
module crc_serial_frontend
  import crc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = CRC_DATA_WIDTH,
  parameter int unsigned CRC_WIDTH  = CRC_CRC_WIDTH,
  parameter int unsigned TIMEOUT    = CRC_TIMEOUT
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  crc_clr,
  output logic                  ser_data,
  output logic                  ser_active,
  input  logic                  crc_bit,
  input  logic                  crc_valid,
  output logic [CRC_WIDTH-1:0]  out_crc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  err_timeout
);

  localparam int unsigned CNT_W = $clog2(max_u(DATA_WIDTH, CRC_WIDTH) + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CRC_DONE   = CNT_W'(CRC_WIDTH);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT - 1);

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]      cnt;
  logic [TMO_W-1:0]      tmo;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      crc_clr     <= 1'b0;
      ser_data    <= 1'b0;
      ser_active  <= 1'b0;
      out_crc     <= '0;
      out_valid   <= 1'b0;
      err_timeout <= 1'b0;
      shreg       <= '0;
      cnt         <= '0;
      tmo         <= '0;
    end else begin
      crc_clr     <= 1'b0;
      err_timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            shreg    <= in_data;
            in_ready <= 1'b0;
            crc_clr  <= 1'b1;
            state    <= CLR;
          end
        end
        CLR: begin
          // Bit 0 is presented as SHIFT is entered so ser_active spans exactly DATA_WIDTH cycles.
          ser_active <= 1'b1;
          ser_data   <= shreg[0];
          shreg      <= shreg >> 1;
          cnt        <= '0;
          state      <= SHIFT;
        end
        SHIFT: begin
          if (cnt == LAST_SHIFT) begin
            ser_active <= 1'b0;
            ser_data   <= 1'b0;
            cnt        <= '0;
            tmo        <= '0;
            state      <= COLLECT;
          end else begin
            ser_data <= shreg[0];
            shreg    <= shreg >> 1;
            cnt      <= cnt + CNT_W'(1);
          end
        end
        COLLECT: begin
          // The completed word is published one cycle after the last sample lands.
          if (cnt == CRC_DONE) begin
            out_valid <= 1'b1;
            state     <= HOLD;
          end else if (crc_valid) begin
            out_crc <= (out_crc >> 1) | (CRC_WIDTH'(crc_bit) << (CRC_WIDTH - 1));
            cnt     <= cnt + CNT_W'(1);
            tmo     <= '0;
          end else if (tmo == TMO_LAST) begin
            err_timeout <= 1'b1;
            in_ready    <= 1'b1;
            state       <= IDLE;
          end else begin
            tmo <= tmo + TMO_W'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc_serial_frontend.sv
// Scoreboard bench for crc_serial_frontend with a behavioural serial CRC-8 (poly 0x07) engine.
module tb_crc_serial_frontend;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       crc_clr;
  logic       ser_data;
  logic       ser_active;
  logic       crc_bit;
  logic       crc_valid;
  logic [7:0] out_crc;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       err_timeout;

  crc_serial_frontend #(
    .DATA_WIDTH(8),
    .CRC_WIDTH (8),
    .TIMEOUT   (32)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .crc_clr    (crc_clr),
    .ser_data   (ser_data),
    .ser_active (ser_active),
    .crc_bit    (crc_bit),
    .crc_valid  (crc_valid),
    .out_crc    (out_crc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .err_timeout(err_timeout)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] crc;
    int         lat;
    int         acc;
  } exp_t;

  exp_t       outq[$];
  logic [7:0] serq[$];

  int eng_gap    = 0;
  bit eng_silent = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bytewise CRC-8 reference: LSB-first serial feed equals MSB-first CRC of the reversed byte.
  function automatic logic [7:0] crc8_ref(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  // Engine model: serial LFSR fed from ser_data, emits its register LSB-first afterwards.
  logic [7:0] lfsr;
  always @(posedge CLK or posedge RST) begin
    if (RST) lfsr <= '0;
    else if (crc_clr) lfsr <= '0;
    else if (ser_active) lfsr <= {lfsr[6:0], 1'b0} ^ (((lfsr[7] ^ ser_data) != 1'b0) ? 8'h07 : 8'h00);
  end

  initial begin
    logic la;
    la = 1'b0;
    crc_valid = 1'b0;
    crc_bit = 1'b0;
    forever begin
      @(negedge CLK);
      if (la && !ser_active && !eng_silent) begin
        for (int i = 0; i < 8; i++) begin
          if (i == 4) begin
            repeat (eng_gap) begin
              crc_valid = 1'b0;
              @(negedge CLK);
            end
          end
          crc_valid = 1'b1;
          crc_bit = lfsr[i];
          @(negedge CLK);
        end
        crc_valid = 1'b0;
        crc_bit = 1'b0;
      end
      la = ser_active;
    end
  end

  // Monitor: serial stream and parallel output checked against queued expectations.
  initial begin
    logic       la, pv;
    logic [7:0] cap;
    int         acnt, ccnt;
    exp_t       cur;
    la = 1'b0; pv = 1'b0; cap = '0; acnt = 0; ccnt = 0;
    cur = '{crc: 8'h00, lat: 0, acc: 0};
    forever begin
      @(negedge CLK);
      if (!RST) begin
        if (crc_clr) ccnt++;
        if (ser_active) begin
          cap = {ser_data, cap[7:1]};
          acnt++;
        end
        if (la && !ser_active) begin
          if (serq.size() != 0) begin
            check("ser_bits", cap, serq.pop_front());
            check("ser_active_len", acnt, 8);
            check("crc_clr_pulses", ccnt, 1);
          end
          acnt = 0;
          ccnt = 0;
        end
        if (out_valid && !pv) begin
          if (outq.size() == 0) begin
            check("unexpected_out_valid", 1, 0);
          end else begin
            cur = outq.pop_front();
            check("out_crc", out_crc, cur.crc);
            check("out_latency", cyc - cur.acc, cur.lat);
          end
        end else if (out_valid && pv) begin
          check("hold_out_crc", out_crc, cur.crc);
          check("hold_in_ready", in_ready, 0);
        end
      end else begin
        acnt = 0;
        ccnt = 0;
      end
      pv = out_valid;
      la = ser_active;
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] d, output int acc);
    in_data = d;
    in_valid = 1'b1;
    acc = -1;
    for (int k = 0; k < 80; k++) begin
      if (in_ready) begin
        @(posedge CLK);
        @(negedge CLK);
        acc = cyc;
        break;
      end
      @(negedge CLK);
    end
    in_valid = 1'b0;
    if (acc < 0) check("accept_bound", 0, 1);
  endtask

  task automatic wait_out();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    if (!seen) check("out_valid_bound", 0, 1);
  endtask

  task automatic frame(input logic [7:0] d, input logic [7:0] e, input int gap);
    int acc;
    eng_gap = gap;
    out_ready = 1'b1;
    serq.push_back(d);
    send(d, acc);
    outq.push_back('{crc: e, lat: 18 + gap, acc: acc});
    wait_out();
    @(negedge CLK);
  endtask

  typedef struct {
    logic [7:0] d;
    logic [7:0] e;
  } vec_t;

  vec_t vecs[6] = '{
    '{d: 8'hA5, e: 8'h72}, '{d: 8'h00, e: 8'h00}, '{d: 8'h01, e: 8'h89},
    '{d: 8'h80, e: 8'h07}, '{d: 8'hFF, e: 8'hF3}, '{d: 8'h02, e: 8'hC7}
  };

  initial begin
    int a1, a2, acc;
    logic [7:0] w;
    bit seen;

    repeat (3) @(negedge CLK);
    check("reset_ctrl", {in_ready, crc_clr, ser_data, ser_active, out_valid, err_timeout}, 6'b100000);
    check("reset_out_crc", out_crc, 8'h00);
    RST = 1'b0;
    @(negedge CLK);

    foreach (vecs[i]) frame(vecs[i].d, vecs[i].e, 0);

    // Back-to-back frames with out_ready held high.
    eng_gap = 0;
    serq.push_back(8'h01);
    send(8'h01, a1);
    outq.push_back('{crc: 8'h89, lat: 18, acc: a1});
    serq.push_back(8'h80);
    send(8'h80, a2);
    outq.push_back('{crc: 8'h07, lat: 18, acc: a2});
    check("frame_period", a2 - a1, 20);
    wait_out();
    @(negedge CLK);

    frame(8'hA5, 8'h72, 3);

    // Back-pressure on the output.
    eng_gap = 0;
    out_ready = 1'b0;
    serq.push_back(8'hFF);
    send(8'hFF, acc);
    outq.push_back('{crc: 8'hF3, lat: 18, acc: acc});
    wait_out();
    repeat (5) @(negedge CLK);
    out_ready = 1'b1;
    @(negedge CLK);
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);

    // Silent engine: collection times out.
    eng_silent = 1'b1;
    send(8'h5A, acc);
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (err_timeout) begin
        seen = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    if (!seen) check("timeout_bound", 0, 1);
    check("timeout_latency", cyc - acc, 41);
    check("timeout_in_ready", in_ready, 1);
    check("timeout_out_valid", out_valid, 0);
    @(negedge CLK);
    check("timeout_pulse_width", err_timeout, 0);

    // Asynchronous reset in the middle of SHIFT.
    send(8'h3C, acc);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (ser_active) begin
        seen = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    if (!seen) check("shift_bound", 0, 1);
    repeat (2) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    check("midreset_ctrl", {in_ready, crc_clr, ser_data, ser_active, out_valid, err_timeout}, 6'b100000);
    check("midreset_out_crc", out_crc, 8'h00);
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    eng_silent = 1'b0;
    frame(8'h80, 8'h07, 0);

    for (int i = 0; i < 10; i++) begin
      w = 8'($urandom_range(0, 255));
      frame(w, crc8_ref(w), 0);
    end

    repeat (3) @(negedge CLK);
    check("outq_drained", outq.size(), 0);
    check("serq_drained", serq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish by %0d cycles", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
